alu_req_scheduler: RTL and testbench

- Arbitrates two independent requesters (e.g. front-panel keypad path and a debug/UART command path) onto the single shared 2-bit ALU/divider datapath.
- Sequences each granted command as load A, load B, settle with op applied, then capture.
- Returns result and flag to the originating requester over a valid/ready response handshake.
- Sits between requester front-ends and the ALU top, replacing direct button-driven loads.

---
 rtl/alu_req_scheduler_if.sv | 53 +++++
 rtl/alu_req_scheduler.sv | 142 ++++++++++++++
 tb/tb_alu_req_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_scheduler_if.sv
// Bundle of requester, ALU and response signals shared between the scheduler
// and its surroundings (requester front-ends, ALU top, response consumer).
interface alu_req_scheduler_if #(
  parameter int unsigned DATA_W = 2
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_W-1:0]     req0_a;
  logic [DATA_W-1:0]     req0_b;
  logic [1:0]            req0_op;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_W-1:0]     req1_a;
  logic [DATA_W-1:0]     req1_b;
  logic [1:0]            req1_op;

  logic [DATA_W-1:0]     alu_in_a;
  logic [DATA_W-1:0]     alu_in_b;
  logic                  alu_load_a;
  logic                  alu_load_b;
  logic [1:0]            alu_op;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  alu_flag;

  logic                  rsp_valid;
  logic                  rsp_id;
  logic [2*DATA_W-1:0]   rsp_data;
  logic                  rsp_flag;
  logic                  rsp_ready;

  // Environment view: requesters, ALU and response consumer
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  alu_in_a, alu_in_b, alu_load_a, alu_load_b, alu_op,
    output alu_result, alu_flag,
    input  rsp_valid, rsp_id, rsp_data, rsp_flag,
    output rsp_ready
  );

  // Scheduler view
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output alu_in_a, alu_in_b, alu_load_a, alu_load_b, alu_op,
    input  alu_result, alu_flag,
    output rsp_valid, rsp_id, rsp_data, rsp_flag,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler of two requesters onto one shared ALU/divider.
// Each granted command runs LOAD_A -> LOAD_B -> SETTLE -> RESP and the captured
// result is returned to its owner over a valid/ready response handshake.
module alu_req_scheduler #(
  parameter int unsigned DATA_W        = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_req_scheduler_if.slave bus,
  output logic              busy,
  output logic [CNT_W-1:0]  done_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    SETTLE,
    RESP
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic                id_q, id_d;
  logic [3:0]          settle_q, settle_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic                flag_q, flag_d;
  logic                rid_q, rid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic grant0;
  logic grant1;

  // Arbitration: a lone requester wins; on contention the one not granted last wins
  always_comb begin
    grant0 = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant_q);
    grant1 = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  end

  // Next-state and datapath latch update
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    settle_d     = settle_q;
    data_d       = data_q;
    flag_d       = flag_q;
    rid_d        = rid_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_d          = grant1 ? bus.req1_a  : bus.req0_a;
          b_d          = grant1 ? bus.req1_b  : bus.req0_b;
          op_d         = grant1 ? bus.req1_op : bus.req0_op;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = LOAD_A;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          data_d  = bus.alu_result;
          flag_d  = bus.alu_flag;
          rid_d   = id_q;
          state_d = RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      settle_q     <= '0;
      data_q       <= '0;
      flag_q       <= 1'b0;
      rid_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      settle_q     <= settle_d;
      data_q       <= data_d;
      flag_q       <= flag_d;
      rid_q        <= rid_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output decode; operands and op come straight from the accept-time latch
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.alu_in_a   = a_q;
    bus.alu_in_b   = b_q;
    bus.alu_op     = op_q;
    bus.alu_load_a = (state_q == LOAD_A);
    bus.alu_load_b = (state_q == LOAD_B);
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_id     = rid_q;
    bus.rsp_data   = data_q;
    bus.rsp_flag   = flag_q;
    busy           = (state_q != IDLE);
    done_count     = cnt_q;
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed self-checking bench for alu_req_scheduler with a small ALU model.
module tb_alu_req_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [7:0] done_count;
  int         checks = 0;
  int         errors = 0;
  logic       in_reset = 1'b1;

  alu_req_scheduler_if #(.DATA_W(2)) bus ();

  alu_req_scheduler #(
    .DATA_W(2),
    .SETTLE_CYCLES(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  // ALU model: operand registers loaded by strobes, combinational result
  logic [1:0] alu_a_q = '0;
  logic [1:0] alu_b_q = '0;
  always @(posedge clk) begin
    if (bus.alu_load_a) alu_a_q <= bus.alu_in_a;
    if (bus.alu_load_b) alu_b_q <= bus.alu_in_b;
  end
  always_comb begin
    bus.alu_result = '0;
    bus.alu_flag   = 1'b0;
    case (bus.alu_op)
      2'b00: bus.alu_result = {2'b00, alu_a_q} + {2'b00, alu_b_q};
      2'b01: begin
        bus.alu_result = {2'b00, alu_a_q} - {2'b00, alu_b_q};
        bus.alu_flag   = (alu_a_q < alu_b_q);
      end
      2'b10: bus.alu_result = {2'b00, alu_a_q} * {2'b00, alu_b_q};
      default: begin
        if (alu_b_q == 2'd0) bus.alu_flag = 1'b1;
        else bus.alu_result = {alu_a_q % alu_b_q, alu_a_q / alu_b_q};
      end
    endcase
  end

  // Continuous invariants: exclusive readys and exclusive load strobes
  always @(negedge clk) begin
    if (!in_reset) begin
      checks++;
      if ((bus.req0_ready && bus.req1_ready) !== 1'b0) begin
        errors++;
        $display("FAIL ready_exclusive: got r0=%b r1=%b expected not both", bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if ((bus.alu_load_a && bus.alu_load_b) !== 1'b0) begin
        errors++;
        $display("FAIL load_exclusive: got la=%b lb=%b expected not both", bus.alu_load_a, bus.alu_load_b);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
  endtask

  task automatic apply_reset();
    in_reset = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    in_reset = 1'b0;
  endtask

  // Drive one command and wait for its response; rsp_ready is expected high
  task automatic send_op(input logic id, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] op, output logic [3:0] d, output logic f,
                         output logic rid, output int lat, output logic tmo);
    int n;
    tmo = 1'b0; lat = 0; d = '0; f = 1'b0; rid = 1'b0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; end
    n = 0;
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin tmo = 1'b1; idle_inputs(); return; end
    @(posedge clk); #1;
    idle_inputs();
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.rsp_valid) begin tmo = 1'b1; return; end
    d = bus.rsp_data; f = bus.rsp_flag; rid = bus.rsp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rsp_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL rst_done_count: got %0d expected 0", done_count); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if ({bus.alu_load_a, bus.alu_load_b} !== 2'b00) begin errors++; $display("FAIL rst_loads: got %b expected 00", {bus.alu_load_a, bus.alu_load_b}); end
    checks++; if ({bus.rsp_data, bus.rsp_id, bus.rsp_flag} !== 6'd0) begin errors++; $display("FAIL rst_rsp_payload: got %h expected 0", {bus.rsp_data, bus.rsp_id, bus.rsp_flag}); end
    rst = 1'b1;
    in_reset = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_strobes();
    bus.req0_valid = 1'b1; bus.req0_a = 2'd3; bus.req0_b = 2'd1; bus.req0_op = 2'b00;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if ({bus.alu_load_a, bus.alu_load_b} !== 2'b10) begin errors++; $display("FAIL loada_strobe: got %b expected 10", {bus.alu_load_a, bus.alu_load_b}); end
    checks++; if ({bus.alu_in_a, bus.alu_in_b} !== 4'b1101) begin errors++; $display("FAIL alu_operands: got %b expected 1101", {bus.alu_in_a, bus.alu_in_b}); end
    checks++; if ({busy, bus.req0_ready} !== 2'b10) begin errors++; $display("FAIL loada_busy_ready: got %b expected 10", {busy, bus.req0_ready}); end
    @(posedge clk); #1;
    checks++; if ({bus.alu_load_a, bus.alu_load_b} !== 2'b01) begin errors++; $display("FAIL loadb_strobe: got %b expected 01", {bus.alu_load_a, bus.alu_load_b}); end
    checks++; if (bus.alu_op !== 2'b00) begin errors++; $display("FAIL alu_op_add: got %b expected 00", bus.alu_op); end
    @(posedge clk); #1;
    checks++; if ({bus.alu_load_a, bus.alu_load_b, bus.rsp_valid} !== 3'b000) begin errors++; $display("FAIL settle1: got %b expected 000", {bus.alu_load_a, bus.alu_load_b, bus.rsp_valid}); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL settle2_valid: got %b expected 0", bus.rsp_valid); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL latency4_valid: got %b expected 1", bus.rsp_valid); end
    checks++; if ({bus.rsp_data, bus.rsp_flag, bus.rsp_id} !== 6'b0100_0_0) begin errors++; $display("FAIL add_rsp: got %b expected 010000", {bus.rsp_data, bus.rsp_flag, bus.rsp_id}); end
    @(posedge clk); #1;
    checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_complete: got %b expected 00", {bus.rsp_valid, busy}); end
    checks++; if (done_count !== 8'd1) begin errors++; $display("FAIL add_done_count: got %0d expected 1", done_count); end
  endtask

  task automatic test_sub_mul();
    logic [3:0] d; logic f, rid, tmo; int lat;
    send_op(1'b1, 2'd1, 2'd3, 2'b01, d, f, rid, lat, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL sub_timeout: got %b expected 0", tmo); end
    checks++; if ({d, f, rid} !== 6'b1110_1_1) begin errors++; $display("FAIL sub_rsp: got %b expected 111011", {d, f, rid}); end
    checks++; if (lat != 4) begin errors++; $display("FAIL sub_latency: got %0d expected 4", lat); end
    send_op(1'b0, 2'd2, 2'd3, 2'b10, d, f, rid, lat, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL mul_timeout: got %b expected 0", tmo); end
    checks++; if ({d, f, rid} !== 6'b0110_0_0) begin errors++; $display("FAIL mul_rsp: got %b expected 011000", {d, f, rid}); end
    checks++; if (done_count !== 8'd3) begin errors++; $display("FAIL mul_done_count: got %0d expected 3", done_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] rd [4];
    logic       rf [4];
    logic       ri [4];
    logic       g  [4];
    int ng = 0, nr = 0, cyc = 0;
    apply_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 2'd3; bus.req0_b = 2'd2; bus.req0_op = 2'b11;
    bus.req1_valid = 1'b1; bus.req1_a = 2'd2; bus.req1_b = 2'd0; bus.req1_op = 2'b11;
    #1;
    while (nr < 4 && cyc < 80) begin
      if (ng < 4 && bus.req0_ready) begin g[ng] = 1'b0; ng++; end
      else if (ng < 4 && bus.req1_ready) begin g[ng] = 1'b1; ng++; end
      if (bus.rsp_valid) begin rd[nr] = bus.rsp_data; rf[nr] = bus.rsp_flag; ri[nr] = bus.rsp_id; nr++; end
      if (nr < 4) begin @(posedge clk); #1; cyc++; end
    end
    idle_inputs();
    checks++; if (nr != 4 || ng != 4) begin errors++; $display("FAIL rr_count: got grants=%0d rsps=%0d expected 4 4", ng, nr); end
    else begin
      checks++; if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin errors++; $display("FAIL rr_grants: got %b expected 0101", {g[0], g[1], g[2], g[3]}); end
      checks++; if ({ri[0], ri[1], ri[2], ri[3]} !== 4'b0101) begin errors++; $display("FAIL rr_ids: got %b expected 0101", {ri[0], ri[1], ri[2], ri[3]}); end
      checks++; if ({rd[0], rf[0], rd[2], rf[2]} !== 10'b0101_0_0101_0) begin errors++; $display("FAIL rr_div_req0: got %b expected 0101001010", {rd[0], rf[0], rd[2], rf[2]}); end
      checks++; if ({rf[1], rf[3]} !== 2'b11) begin errors++; $display("FAIL rr_div0_flag: got %b expected 11", {rf[1], rf[3]}); end
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [7:0] dc0, exp_dc;
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 2'd2; bus.req0_b = 2'd3; bus.req0_op = 2'b10;
    #1;
    while (!bus.req0_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout: got %b expected 1", bus.rsp_valid); end
    dc0 = done_count;
    bus.req1_valid = 1'b1; bus.req1_a = 2'd1; bus.req1_b = 2'd1; bus.req1_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.rsp_valid, bus.rsp_data, bus.rsp_flag, bus.rsp_id} !== 7'b1_0110_0_0) begin errors++; $display("FAIL bp_hold_%0d: got %b expected 1011000", i, {bus.rsp_valid, bus.rsp_data, bus.rsp_flag, bus.rsp_id}); end
      checks++; if ({bus.req0_ready, bus.req1_ready, done_count} !== {2'b00, dc0}) begin errors++; $display("FAIL bp_stall_%0d: got %h expected %h", i, {bus.req0_ready, bus.req1_ready, done_count}, {2'b00, dc0}); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_dc = dc0 + 8'd1;
    checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got %b expected 00", {bus.rsp_valid, busy}); end
    checks++; if (done_count !== exp_dc) begin errors++; $display("FAIL bp_done_count: got %0d expected %0d", done_count, exp_dc); end
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b expected 1", bus.req1_ready); end
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (done_count !== exp_dc) begin errors++; $display("FAIL bp_single_inc: got %0d expected %0d", done_count, exp_dc); end
  endtask

  task automatic test_reset_midop();
    int n = 0, seen = 0;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 2'd1; bus.req0_b = 2'd1; bus.req0_op = 2'b01;
    #1;
    while (!bus.req0_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) begin @(posedge clk); #1; end
    checks++; if ({busy, bus.alu_op} !== 3'b101) begin errors++; $display("FAIL midop_in_settle: got %b expected 101", {busy, bus.alu_op}); end
    #2 rst = 1'b0; in_reset = 1'b1;
    #1;
    checks++; if ({busy, bus.rsp_valid, bus.alu_load_a, bus.alu_load_b} !== 4'b0000) begin errors++; $display("FAIL midop_async_ctrl: got %b expected 0000", {busy, bus.rsp_valid, bus.alu_load_a, bus.alu_load_b}); end
    checks++; if ({bus.alu_in_a, bus.alu_in_b, bus.alu_op, bus.rsp_data} !== 10'd0) begin errors++; $display("FAIL midop_async_data: got %b expected 0", {bus.alu_in_a, bus.alu_in_b, bus.alu_op, bus.rsp_data}); end
    checks++; if (done_count !== 8'd0) begin errors++; $display("FAIL midop_done_count: got %0d expected 0", done_count); end
    @(posedge clk); #1;
    rst = 1'b1; in_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midop_no_rsp: got %0d responses expected 0", seen); end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL midop_first_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc = 0, nacc = 0, bad = 0, last = 0;
    logic [7:0] dc_at = '0;
    apply_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 2'd2; bus.req0_b = 2'd1; bus.req0_op = 2'b00;
    #1;
    while (nacc < 256 && cyc < 2000) begin
      if (bus.req0_ready) begin
        if (nacc > 0 && (cyc - last) != 6) bad++;
        if (nacc == 255) dc_at = done_count;
        last = cyc;
        nacc++;
      end
      @(posedge clk); #1; cyc++;
    end
    idle_inputs();
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (nacc != 256) begin errors++; $display("FAIL b2b_accepts: got %0d expected 256", nacc); end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_interval: got %0d bad intervals expected 0", bad); end
    checks++; if (dc_at !== 8'd255) begin errors++; $display("FAIL b2b_count_255: got %0d expected 255", dc_at); end
    checks++; if ({busy, done_count} !== 9'd0) begin errors++; $display("FAIL b2b_wrap: got busy=%b count=%0d expected 0 0", busy, done_count); end
  endtask

  initial begin
    test_reset();
    test_single_strobes();
    test_sub_mul();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
